// File: rtl/mvau_stream_axi_if.sv
// Stream bundle for the matrix-vector unit: activation and weight tiles in,
// per-PE results out, each with a valid/ready handshake.
interface mvau_stream_axi_if #(
  parameter int SIMD  = 2,
  parameter int PE    = 2,
  parameter int TSrcI = 8,
  parameter int TW    = 8,
  parameter int TDstI = 16
);
  logic [SIMD*TSrcI-1:0]  in_act;
  logic                   in_act_valid;
  logic                   in_act_ready;
  logic [PE*SIMD*TW-1:0]  in_wgt;
  logic                   in_wgt_valid;
  logic                   in_wgt_ready;
  logic [PE*TDstI-1:0]    out;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    output in_act, in_act_valid, in_wgt, in_wgt_valid, out_ready,
    input  in_act_ready, in_wgt_ready, out, out_valid
  );

  modport slave (
    input  in_act, in_act_valid, in_wgt, in_wgt_valid, out_ready,
    output in_act_ready, in_wgt_ready, out, out_valid
  );
endinterface

// File: rtl/mvau_stream_axi.sv
// Streaming matrix-vector unit: SIMD x PE tile per fire, activations buffered
// on the first row-fold and reused for the remaining NF-1 folds.
//
// state | meaning
// FILL  | nf_cnt = 0, activations consumed from in_act and written to the buffer
// REUSE | nf_cnt > 0, activations replayed from the buffer, only weights consumed
module mvau_stream_axi #(
  parameter int SIMD    = 2,
  parameter int PE      = 2,
  parameter int MatrixW = 4,
  parameter int MatrixH = 4,
  parameter int TSrcI   = 8,
  parameter int TW      = 8,
  parameter int TDstI   = 16,
  parameter int MODE    = 0
) (
  input  logic              clk,
  input  logic              rst,
  mvau_stream_axi_if.slave  bus
);
  localparam int SF   = MatrixW / SIMD;
  localparam int NF   = MatrixH / PE;
  localparam int SF_T = (SF > 1) ? $clog2(SF) : 1;
  localparam int NF_T = (NF > 1) ? $clog2(NF) : 1;
  // wide enough for an unsigned-extended activation times a signed weight
  localparam int PW   = TSrcI + TW + 1;

  typedef enum logic {FILL, REUSE} state_t;

  state_t                 state;
  logic [SF_T-1:0]        sf_cnt;
  logic [NF_T-1:0]        nf_cnt;
  logic [SIMD*TSrcI-1:0]  act_buf [SF];
  logic [TDstI-1:0]       acc     [PE];
  logic [TDstI-1:0]       acc_nxt [PE];
  logic [TDstI-1:0]       sum     [PE];
  logic [PE*TDstI-1:0]    out_q;
  logic                   out_valid_q;

  logic                   sf_last;
  logic                   stall;
  logic                   fire;
  logic [SIMD*TSrcI-1:0]  act;
  logic [TSrcI-1:0]       a;
  logic [TW-1:0]          w;
  logic signed [PW-1:0]   ax;
  logic signed [PW-1:0]   wx;
  logic signed [PW-1:0]   prod;

  assign sf_last = (sf_cnt == SF_T'(SF - 1));
  assign stall   = out_valid_q & ~bus.out_ready & sf_last;

  always_comb begin
    bus.in_act_ready = 1'b0;
    bus.in_wgt_ready = 1'b0;
    if (!rst) begin
      if (state == FILL) begin
        bus.in_act_ready = ~stall & bus.in_wgt_valid;
        bus.in_wgt_ready = ~stall & bus.in_act_valid;
      end else begin
        bus.in_wgt_ready = ~stall;
      end
    end
  end

  assign fire = (state == FILL)
              ? (bus.in_act_valid & bus.in_act_ready & bus.in_wgt_valid & bus.in_wgt_ready)
              : (bus.in_wgt_valid & bus.in_wgt_ready);

  assign act = (state == FILL) ? bus.in_act : act_buf[sf_cnt];

  always_comb begin
    a    = '0;
    w    = '0;
    ax   = '0;
    wx   = '0;
    prod = '0;
    for (int p = 0; p < PE; p++) begin
      sum[p] = '0;
      for (int i = 0; i < SIMD; i++) begin
        a = act[i*TSrcI +: TSrcI];
        w = bus.in_wgt[(p*SIMD+i)*TW +: TW];
        if (MODE == 2) begin
          prod = PW'({1'b0, ~(a[0] ^ w[0])});
        end else begin
          if (MODE == 1) ax = PW'($signed({1'b0, a}));
          else           ax = PW'($signed(a));
          wx   = PW'($signed(w));
          prod = ax * wx;
        end
        sum[p] = sum[p] + TDstI'(prod);
      end
      acc_nxt[p] = ((sf_cnt == '0) ? '0 : acc[p]) + sum[p];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FILL;
      sf_cnt      <= '0;
      nf_cnt      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      for (int p = 0; p < PE; p++) acc[p] <= '0;
    end else begin
      if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
      if (fire) begin
        for (int p = 0; p < PE; p++) acc[p] <= acc_nxt[p];
        if (sf_last) begin
          sf_cnt      <= '0;
          out_valid_q <= 1'b1;
          for (int p = 0; p < PE; p++) out_q[p*TDstI +: TDstI] <= acc_nxt[p];
          if (nf_cnt == NF_T'(NF - 1)) begin
            nf_cnt <= '0;
            state  <= FILL;
          end else begin
            nf_cnt <= nf_cnt + 1'b1;
            state  <= REUSE;
          end
        end else begin
          sf_cnt <= sf_cnt + 1'b1;
        end
      end
    end
  end

  // buffer contents survive reset; they are always rewritten in FILL before use
  always_ff @(posedge clk) begin
    if (fire && state == FILL) act_buf[sf_cnt] <= bus.in_act;
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_mvau_stream_axi.sv
// Bench for mvau_stream_axi: randomized images against a matrix-vector model,
// plus small fixed-configuration instances for the corner cases.
module tb_mvau_stream_axi;
  localparam int A_SIMD = 2, A_PE = 2, A_W = 4, A_H = 4;
  localparam int A_SF = A_W / A_SIMD, A_NF = A_H / A_PE;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  mvau_stream_axi_if #(.SIMD(2), .PE(2), .TSrcI(8), .TW(8), .TDstI(16)) a_if ();
  mvau_stream_axi_if #(.SIMD(2), .PE(1), .TSrcI(8), .TW(8), .TDstI(16)) b_if ();
  mvau_stream_axi_if #(.SIMD(8), .PE(1), .TSrcI(1), .TW(1), .TDstI(16)) c_if ();
  mvau_stream_axi_if #(.SIMD(2), .PE(1), .TSrcI(8), .TW(8), .TDstI(8))  d_if ();

  mvau_stream_axi #(.SIMD(2), .PE(2), .MatrixW(4), .MatrixH(4), .TSrcI(8), .TW(8), .TDstI(16), .MODE(0))
    dut_a (.clk(clk), .rst(rst), .bus(a_if));
  mvau_stream_axi #(.SIMD(2), .PE(1), .MatrixW(2), .MatrixH(1), .TSrcI(8), .TW(8), .TDstI(16), .MODE(0))
    dut_b (.clk(clk), .rst(rst), .bus(b_if));
  mvau_stream_axi #(.SIMD(8), .PE(1), .MatrixW(8), .MatrixH(1), .TSrcI(1), .TW(1), .TDstI(16), .MODE(2))
    dut_c (.clk(clk), .rst(rst), .bus(c_if));
  mvau_stream_axi #(.SIMD(2), .PE(1), .MatrixW(4), .MatrixH(1), .TSrcI(8), .TW(8), .TDstI(8), .MODE(1))
    dut_d (.clk(clk), .rst(rst), .bus(d_if));

  logic [15:0] act_q[$];
  logic [31:0] wgt_q[$];
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // One image = activation vector x and matrix M; expected output rows are M*x mod 2^16.
  task automatic build_images(input int n_img, input bit ones);
    int x[A_W];
    int m[A_H][A_W];
    logic [15:0] at;
    logic [31:0] wt;
    logic [31:0] res;
    int s;
    act_q.delete(); wgt_q.delete(); exp_q.delete();
    for (int img = 0; img < n_img; img++) begin
      for (int j = 0; j < A_W; j++) begin
        x[j] = ones ? j + 1 : int'($urandom_range(255)) - 128;
        for (int r = 0; r < A_H; r++) m[r][j] = ones ? 1 : int'($urandom_range(255)) - 128;
      end
      for (int sf = 0; sf < A_SF; sf++) begin
        at = '0;
        for (int i = 0; i < A_SIMD; i++) at[i*8 +: 8] = 8'(x[sf*A_SIMD+i]);
        act_q.push_back(at);
      end
      for (int nf = 0; nf < A_NF; nf++) begin
        for (int sf = 0; sf < A_SF; sf++) begin
          wt = '0;
          for (int p = 0; p < A_PE; p++)
            for (int i = 0; i < A_SIMD; i++) wt[(p*A_SIMD+i)*8 +: 8] = 8'(m[nf*A_PE+p][sf*A_SIMD+i]);
          wgt_q.push_back(wt);
        end
        res = '0;
        for (int p = 0; p < A_PE; p++) begin
          s = 0;
          for (int j = 0; j < A_W; j++) s += x[j] * m[nf*A_PE+p][j];
          res[p*16 +: 16] = 16'(s);
        end
        exp_q.push_back(res);
      end
    end
  endtask

  task automatic run_images(input int n_img, input bit ones, input bit rnd, input int abort_fires);
    bit af = 0, wf = 0, hold = 0;
    int ai = 0, wi = 0, fires = 0, acts = 0;
    logic [31:0] last_out = '0;
    build_images(n_img, ones);
    if (ones) check("model_pin_all_ones", exp_q[0], 64'h000A_000A);
    for (int cyc = 0; ; cyc++) begin
      if (af) ai++;
      if (wf) wi++;
      if (ai == act_q.size() && wi == wgt_q.size() && exp_q.size() == 0) break;
      if (cyc >= 4000) begin fail_now("stream_timeout"); break; end
      if (!(a_if.in_act_valid && !af))
        a_if.in_act_valid = (ai < act_q.size()) && (!rnd || $urandom_range(3) != 0);
      if (!(a_if.in_wgt_valid && !wf))
        a_if.in_wgt_valid = (wi < wgt_q.size()) && (!rnd || $urandom_range(3) != 0);
      a_if.in_act = (ai < act_q.size()) ? act_q[ai] : '0;
      a_if.in_wgt = (wi < wgt_q.size()) ? wgt_q[wi] : '0;
      a_if.out_ready = (abort_fires > 0) ? 1'b0 : (!rnd || $urandom_range(2) != 0);
      @(negedge clk);
      af = a_if.in_act_valid && a_if.in_act_ready;
      wf = a_if.in_wgt_valid && a_if.in_wgt_ready;
      if ((wi % (A_SF*A_NF)) >= A_SF) check("act_ready_in_reuse", a_if.in_act_ready, 0);
      if (a_if.out_valid && !a_if.out_ready && (wi % A_SF) == A_SF - 1)
        check("wgt_ready_stall", a_if.in_wgt_ready, 0);
      if (hold) begin
        check("out_hold", a_if.out, last_out);
        check("valid_hold", a_if.out_valid, 1);
      end
      if (a_if.out_valid && a_if.out_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_result");
        else check("result", a_if.out, exp_q.pop_front());
      end
      hold = a_if.out_valid && !a_if.out_ready;
      last_out = a_if.out;
      if (af) acts++;
      if (wf) fires++;
      @(posedge clk); #1;
      if (abort_fires > 0 && fires == abort_fires) begin
        rst = 1'b1;
        #1;
        check("abort_out_valid", a_if.out_valid, 0);
        check("abort_out", a_if.out, 0);
        check("abort_act_ready", a_if.in_act_ready, 0);
        check("abort_wgt_ready", a_if.in_wgt_ready, 0);
        a_if.in_act_valid = 1'b0;
        a_if.in_wgt_valid = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
    end
    a_if.in_act_valid = 1'b0;
    a_if.in_wgt_valid = 1'b0;
    if (ones) check("act_transfers", acts, A_SF * n_img);
  endtask

  initial begin
    int cnt;
    a_if.in_act = 16'h0201; a_if.in_wgt = 32'h0101_0101;
    a_if.in_act_valid = 1'b1; a_if.in_wgt_valid = 1'b1; a_if.out_ready = 1'b1;
    b_if.in_act = '0; b_if.in_wgt = '0; b_if.in_act_valid = 0; b_if.in_wgt_valid = 0; b_if.out_ready = 1;
    c_if.in_act = '0; c_if.in_wgt = '0; c_if.in_act_valid = 0; c_if.in_wgt_valid = 0; c_if.out_ready = 1;
    d_if.in_act = '0; d_if.in_wgt = '0; d_if.in_act_valid = 0; d_if.in_wgt_valid = 0; d_if.out_ready = 1;

    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", a_if.out_valid, 0);
    check("reset_out", a_if.out, 0);
    check("reset_act_ready", a_if.in_act_ready, 0);
    check("reset_wgt_ready", a_if.in_wgt_ready, 0);
    a_if.in_act_valid = 1'b0;
    a_if.in_wgt_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    run_images(1, 1'b1, 1'b0, 0);
    run_images(40, 1'b0, 1'b1, 0);
    run_images(1, 1'b0, 1'b0, 3);
    run_images(1, 1'b0, 1'b0, 0);
    run_images(10, 1'b0, 1'b1, 0);

    // SF = 1 signed dot product: [-3,5] . [2,-1] = -11
    b_if.in_act = {8'd5, 8'hFD}; b_if.in_wgt = {8'hFF, 8'h02};
    b_if.in_act_valid = 1; b_if.in_wgt_valid = 1;
    cnt = 0;
    for (int k = 0; k < 50 && cnt < 1; k++) begin
      @(negedge clk);
      if (b_if.in_act_ready && b_if.in_wgt_ready) cnt++;
    end
    if (cnt < 1) fail_now("sf1_handshake");
    @(posedge clk); #1;
    b_if.in_act_valid = 0; b_if.in_wgt_valid = 0;
    check("sf1_latency", b_if.out_valid, 1);
    check("sf1_signed_dot", b_if.out, 16'hFFF5);
    @(posedge clk); #1;
    check("sf1_valid_clear", b_if.out_valid, 0);

    // XNOR popcount: one differing bit out of eight
    c_if.in_act = 8'b1011_0010; c_if.in_wgt = 8'b1011_0011;
    c_if.in_act_valid = 1; c_if.in_wgt_valid = 1;
    cnt = 0;
    for (int k = 0; k < 50 && cnt < 1; k++) begin
      @(negedge clk);
      if (c_if.in_act_ready && c_if.in_wgt_ready) cnt++;
    end
    if (cnt < 1) fail_now("xnor_handshake");
    @(posedge clk); #1;
    c_if.in_act_valid = 0; c_if.in_wgt_valid = 0;
    check("xnor_valid", c_if.out_valid, 1);
    check("xnor_popcount", c_if.out, 16'd7);

    // 8-bit accumulator, 255*127 four times: 129540 mod 256 = 4
    d_if.in_act = 16'hFFFF; d_if.in_wgt = 16'h7F7F;
    d_if.in_act_valid = 1; d_if.in_wgt_valid = 1;
    cnt = 0;
    for (int k = 0; k < 50 && cnt < 2; k++) begin
      @(negedge clk);
      if (d_if.in_act_ready && d_if.in_wgt_ready) cnt++;
      if (cnt == 1) check("wrap_no_early_valid", d_if.out_valid, 0);
    end
    if (cnt < 2) fail_now("wrap_handshake");
    @(posedge clk); #1;
    d_if.in_act_valid = 0; d_if.in_wgt_valid = 0;
    check("wrap_valid", d_if.out_valid, 1);
    check("wrap_mod256", d_if.out, 8'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
